// File: rtl/comp_pkg.sv
// Shared types, default sizes and the round-robin grant search used by
// comp_arbiter.
package comp_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNT_W = 8;

  // Upper bound on requesters the grant search can handle.
  localparam int RR_MAX = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First valid requester at or after ptr, wrapping modulo nreq.
  // ptr must be below nreq, so a candidate never needs more than one
  // subtraction to wrap.
  function automatic rr_pick_t rr_next_grant(input logic [RR_MAX-1:0] valid,
                                             input int unsigned       nreq,
                                             input int unsigned       ptr);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      cand = ptr + k;
      if (cand >= nreq) cand = cand - nreq;
      if (k < nreq) begin
        if (!res.found && valid[cand[4:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[4:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/comp_arbiter_comparator.sv
// Unsigned magnitude comparator. Flag naming follows the shared datapath:
// ST means A below B, LT means A above B. Purely combinational.
module comparator #(
  parameter int WIDTH = comp_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ST,
  output logic             EQ,
  output logic             LT
);

  // Exactly one flag is high for any operand pair.
  always_comb begin
    ST = (A < B);
    EQ = (A == B);
    LT = (A > B);
  end

endmodule

// File: rtl/comp_arbiter.sv
// Round-robin front end that lets NREQ producers share one comparator.
// Each grant runs operand capture -> compare -> respond.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | searching for a valid requester from rr_ptr; grant is
//           | combinational and operands are captured on transfer
//   COMPARE | comparator sees only the operand registers; flags captured
//   RESPOND | rsp_valid high, fields held until rsp_ready
module comp_arbiter
  import comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int ID_W  = $clog2(NREQ),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_st,
  output logic                  rsp_eq,
  output logic                  rsp_lt,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_cnt
);

  state_e           state_q;
  state_e           state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;

  rr_pick_t         pick;
  logic [ID_W-1:0]  grant_id;
  logic             xfer;
  logic             rsp_done;
  logic             cmp_st;
  logic             cmp_eq;
  logic             cmp_lt;

  // Round-robin search over the currently valid requesters.
  always_comb begin
    pick     = rr_next_grant(RR_MAX'(req_valid), NREQ, int'(rr_ptr_q));
    grant_id = ID_W'(pick.idx);
  end

  // Grant is offered only in IDLE and never while reset is asserted, so
  // nothing can be accepted in the cycle that reset clears the FSM.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && pick.found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Handshake qualifiers and status outputs derived from the state.
  always_comb begin
    xfer      = (req_ready != '0);
    rsp_valid = (state_q == RESPOND);
    busy      = (state_q != IDLE);
    rsp_done  = rsp_valid && rsp_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = COMPARE;
      COMPARE: state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand and id capture on transfer; later producer changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      rsp_id <= '0;
    end else if (xfer) begin
      op_a_q <= req_a[grant_id*WIDTH +: WIDTH];
      op_b_q <= req_b[grant_id*WIDTH +: WIDTH];
      rsp_id <= grant_id;
    end
  end

  comparator #(
    .WIDTH (WIDTH)
  ) u_comparator (
    .A  (op_a_q),
    .B  (op_b_q),
    .ST (cmp_st),
    .EQ (cmp_eq),
    .LT (cmp_lt)
  );

  // Result flags latch once in COMPARE and stay put through RESPOND.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_st <= 1'b0;
      rsp_eq <= 1'b0;
      rsp_lt <= 1'b0;
    end else if (state_q == COMPARE) begin
      rsp_st <= cmp_st;
      rsp_eq <= cmp_eq;
      rsp_lt <= cmp_lt;
    end
  end

  // Pointer moves past the requester just served; counter wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      done_cnt <= '0;
    end else if (rsp_done) begin
      rr_ptr_q <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + ID_W'(1);
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/comp_arbiter.md
Name: comp_arbiter

Overview:
- Shares one combinational 4-bit magnitude comparator among NREQ requesters.
- Round-robin arbitration; each grant runs a registered operand → compare → respond sequence.
- Sits between operand producers and the `comparator` datapath instance; returns ST/EQ/LT flags tagged with requester id.
- Keeps a completed-transaction counter for status.

Parameters:
- WIDTH, 4, operand width in bits.
- NREQ, 4, number of requesters (≥2).
- ID_W, $clog2(NREQ), requester id width.
- CNT_W, 8, width of completed-transaction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing.
- req_ready  out  NREQ  one-hot grant/accept; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_st  out  1  A < B.
- rsp_eq  out  1  A == B.
- rsp_lt  out  1  A > B.
- busy  out  1  high in COMPARE and RESPOND.
- done_cnt  out  CNT_W  number of responses accepted by the consumer.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE; rr_ptr = 0.
  - rsp_valid, rsp_st, rsp_eq, rsp_lt, rsp_id, busy, done_cnt all = 0.
  - Operand registers = 0.
  - req_ready = 0 while rst is high.
- Reset mid-transaction drops that transaction silently. No response is issued and done_cnt is not incremented.
- IDLE state:
  - Grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[grant] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - If no requester is valid, req_ready = 0 and the FSM stays in IDLE.
  - On transfer: capture A, B and grant id into registers; next state = COMPARE.
- COMPARE state:
  - Comparator inputs are driven only from the operand registers.
  - Capture ST/EQ/LT into the response registers; next state = RESPOND.
- RESPOND state:
  - rsp_valid = 1. Response fields are held stable while rsp_valid & !rsp_ready.
  - On rsp_ready = 1: done_cnt += 1 (wraps modulo 2^CNT_W); rr_ptr = (rsp_id + 1) mod NREQ; next state = IDLE.
- req_ready is 0 in COMPARE and RESPOND.
- Timing:
  - Request accepted at cycle t gives rsp_valid at t+2.
  - Minimum issue interval is 3 cycles per transaction.
- Flags are mutually exclusive; exactly one is 1 whenever rsp_valid = 1. Comparison is unsigned over WIDTH bits.
- Fairness: a continuously valid requester is served within NREQ grants.
- rr_ptr wraps from NREQ-1 to 0.
- req_valid may deassert without a transfer; no requester state is kept.
- Changes to req_a/req_b after the transfer have no effect on the in-flight result.

Decomposition:
- Package comp_pkg contains:
  - state enum {IDLE, COMPARE, RESPOND} (2-bit encoding);
  - default WIDTH/NREQ constants;
  - a round-robin next-grant function.
- Sub-module: `comparator` (ports A, B, ST, EQ, LT; purely combinational), instantiated once inside comp_arbiter.
- Arbiter, FSM, response registers and counter stay in comp_arbiter.

Test Plan:
1. Reset, then requester 0 sends A=1, B=1 with rsp_ready=1.
   → req_ready=0001 in the accept cycle; rsp_valid 2 cycles later; rsp_id=0, eq=1, st=0, lt=0; done_cnt=1.
2. Requester 2 sends A=5, B=1; rsp_ready held 0 for 4 cycles.
   → lt=1 and rsp_id=2 held stable for all 4 cycles; busy=1; req_ready=0000 throughout; done_cnt increments once, on release.
3. All 4 requesters valid continuously, operands A=i, B=3.
   → grant order 0,1,2,3,0; results st,st,st,eq (no lt) then repeat; each response 3 cycles apart with rsp_ready=1.
4. Requesters 1 and 3 valid, rr_ptr=2 after serving requester 1.
   → next grant is 3, then 1; A=0, B=3 gives st=1; A=8, B=1 gives lt=1.
5. Reset asserted in the COMPARE cycle of A=1, B=8.
   → next cycle rsp_valid=0, state IDLE, done_cnt=0; the dropped transaction never appears.
6. Force done_cnt to 255 (CNT_W=8), then complete one transaction.
   → done_cnt wraps to 0; comparison of A=1, B=0 gives lt=1.
